mem_stage_lsu: RTL

//  Parametrised MEM pipeline stage: decodes EX address into DMEM / IMEM-write / IO regions, aligns

---
 rtl/mem_pkg.sv | 28 ++
 rtl/lsu_align.sv | 37 +++
 rtl/mem_stage_lsu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage load/store unit
// Provides region codes, RV32I funct3 width codes, the IO FSM state and the
// control bundle carried from MEM into WB for load extraction.
package mem_pkg;
    localparam logic [3:0] REG_DMEM      = 4'b0001;
    localparam logic [3:0] REG_DMEM_IMEM = 4'b0011;
    localparam logic [3:0] REG_IMEM      = 4'b0010;
    localparam logic [3:0] REG_IO        = 4'b1000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} io_state_t;

    typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_DMEM = 2'd1, SRC_IO = 2'd2} ld_src_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
        ld_src_t    src;
    } ld_ctl_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication / byte enables, misalign detect, load extract + extend
// Ports: st_size/st_lane/st_data -> din/be/misalign (MEM cycle);
//        ld_funct3/ld_lane/ld_raw -> ld_data (WB cycle, fed by latched control).
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] din,
    output logic [3:0]  be,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);
    logic [15:0] sh;

    always_comb begin
        din      = st_size == SZ_B ? {4{st_data[7:0]}} :
                   st_size == SZ_H ? {2{st_data[15:0]}} : st_data;
        be       = st_size == SZ_B ? 4'b0001 << st_lane :
                   st_size == SZ_H ? 4'b0011 << {st_lane[1], 1'b0} : 4'hF;
        misalign = (st_size == SZ_H && st_lane[0]) || (st_size == SZ_W && st_lane != 2'b00);
    end

    // Shifting the addressed lane down to bit 0 serves both byte and half loads.
    assign sh = 16'(ld_raw >> {ld_lane, 3'b000});

    always_comb begin
        ld_data = ld_funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
                  ld_funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
                  ld_funct3 == F3_LBU ? {24'b0, sh[7:0]} :
                  ld_funct3 == F3_LHU ? {16'b0, sh[15:0]} : ld_raw;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with DMEM/IMEM-write/IO decode and MEM->WB register
// Ports: in_* from EX, flush kills the MEM instruction, stall_o holds EX;
//        dmem_* sync data memory, imem_* instruction-memory write port,
//        io_* request/ack bus with timeout, wb_* registered MEM->WB state,
//        wb_ld_data extracted load result computed in the WB cycle.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DMEM_AW     = 14,
    parameter int IMEM_AW     = 14,
    parameter int IO_MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_addr,
    input  logic [XLEN-1:0]    in_wdata,
    input  logic [2:0]         in_funct3,
    input  logic               in_load,
    input  logic               in_store,
    input  logic [4:0]         in_rd,
    input  logic               flush,
    output logic               stall_o,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_din,
    input  logic [XLEN-1:0]    dmem_dout,
    output logic               imem_en,
    output logic [3:0]         imem_wea,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_din,
    output logic               io_req,
    output logic               io_we,
    output logic [3:0]         io_be,
    output logic [XLEN-1:0]    io_addr,
    output logic [XLEN-1:0]    io_wdata,
    input  logic               io_ack,
    input  logic [XLEN-1:0]    io_rdata,
    output logic               wb_valid,
    output logic [XLEN-1:0]    wb_pc,
    output logic [XLEN-1:0]    wb_alu,
    output logic [4:0]         wb_rd,
    output logic               wb_load,
    output logic [XLEN-1:0]    wb_ld_data,
    output logic               wb_misalign,
    output logic               wb_io_timeout
);
    localparam int CW = $clog2(IO_MAX_WAIT + 1);

    if (XLEN != 32) begin : g_xlen_check
        $error("mem_stage_lsu supports XLEN=32 only");
    end

    io_state_t   state, state_nx;
    logic [CW-1:0] cnt;
    ld_ctl_t     ld_ctl;
    logic [3:0]  region, be;
    logic [31:0] din, io_pc_r, io_rdata_r, ld_raw;
    logic [4:0]  io_rd_r;
    logic [2:0]  io_f3_r;
    logic        io_load_r;
    logic        is_dmem, is_imem, is_io, mem_op, mis, act, idle, start, timeout, done;

    assign region  = in_addr[31:28];
    assign is_dmem = region == REG_DMEM || region == REG_DMEM_IMEM;
    assign is_imem = region == REG_IMEM || region == REG_DMEM_IMEM;
    assign is_io   = region == REG_IO;
    // rst_n is folded in so every enable and stall_o drops the moment reset asserts.
    assign mem_op  = rst_n & in_valid & ~flush & (in_load | in_store);
    assign act     = mem_op & ~mis;
    assign idle    = state == ST_IDLE;
    assign start   = idle & act & is_io;
    assign timeout = cnt == CW'(IO_MAX_WAIT - 1);
    // flush is deliberately absent here: an IO transaction always runs to completion.
    assign done    = ~idle & (io_ack | timeout);
    assign stall_o = start | (~idle & ~io_ack & ~timeout);

    lsu_align u_align (
        .st_size   (in_funct3[1:0]),
        .st_lane   (in_addr[1:0]),
        .st_data   (in_wdata),
        .din       (din),
        .be        (be),
        .misalign  (mis),
        .ld_funct3 (ld_ctl.funct3),
        .ld_lane   (ld_ctl.lane),
        .ld_raw    (ld_raw),
        .ld_data   (wb_ld_data)
    );

    assign dmem_en   = idle & act & is_dmem;
    assign dmem_we   = (dmem_en & in_store) ? be : 4'b0;
    assign dmem_addr = in_addr[DMEM_AW+1:2];
    assign dmem_din  = din;
    assign imem_en   = idle & act & in_store & is_imem;
    assign imem_wea  = imem_en ? be : 4'b0;
    assign imem_addr = in_addr[IMEM_AW+1:2];
    assign imem_din  = din;

    assign ld_raw = ld_ctl.src == SRC_DMEM ? dmem_dout :
                    ld_ctl.src == SRC_IO   ? io_rdata_r : 32'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = start ? ST_WAIT : done ? ST_IDLE : state;
    end

    // io_req is high exactly while in WAIT, so it is the registered state itself.
    always_comb begin
        io_req = state == ST_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (~idle & ~done) ? cnt + 1'b1 : '0;
    end

    // The IO instruction is captured on entry so completion does not depend on EX holding it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_we     <= 1'b0;
            io_be     <= 4'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            io_pc_r   <= '0;
            io_rd_r   <= '0;
            io_f3_r   <= '0;
            io_load_r <= 1'b0;
        end else if (start) begin
            io_we     <= in_store;
            io_be     <= be;
            io_addr   <= in_addr;
            io_wdata  <= din;
            io_pc_r   <= in_pc;
            io_rd_r   <= in_rd;
            io_f3_r   <= in_funct3;
            io_load_r <= in_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_pc         <= '0;
            wb_alu        <= '0;
            wb_rd         <= '0;
            wb_load       <= 1'b0;
            wb_misalign   <= 1'b0;
            wb_io_timeout <= 1'b0;
            io_rdata_r    <= '0;
            ld_ctl        <= '{funct3: 3'b0, lane: 2'b0, src: SRC_NONE};
        end else if (done) begin
            wb_valid      <= 1'b1;
            wb_pc         <= io_pc_r;
            wb_alu        <= io_addr;
            wb_rd         <= io_rd_r;
            wb_load       <= io_load_r;
            wb_misalign   <= 1'b0;
            wb_io_timeout <= ~io_ack;
            io_rdata_r    <= io_ack ? io_rdata : 32'b0;
            ld_ctl.funct3 <= io_f3_r;
            ld_ctl.lane   <= io_addr[1:0];
            ld_ctl.src    <= SRC_IO;
        end else if (stall_o) begin
            wb_valid      <= 1'b0;
        end else begin
            wb_valid      <= rst_n & in_valid & ~flush;
            wb_pc         <= in_pc;
            wb_alu        <= in_addr;
            wb_rd         <= in_rd;
            wb_load       <= in_load;
            wb_misalign   <= mem_op & mis;
            wb_io_timeout <= 1'b0;
            ld_ctl.funct3 <= in_funct3;
            ld_ctl.lane   <= in_addr[1:0];
            ld_ctl.src    <= (act & in_load & is_dmem) ? SRC_DMEM : SRC_NONE;
        end
    end
endmodule
